// File: rtl/euler_result_formatter_if.sv
// Byte stream from the result formatter toward the UART transmitter.
// The master drives data/valid and the slave answers with ready.
interface euler_result_formatter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/euler_result_formatter.sv
// Captures a solver result, converts it to BCD with a serial double-dabble and
// streams it as ASCII digits (or "OVF") with an optional CR LF terminator.
module euler_result_formatter #(
  parameter int WIDTH        = 32,
  parameter int DIGITS       = 10,
  parameter int EMIT_NEWLINE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         value,
  input  logic                     overflow,
  euler_result_formatter_if.master tx,
  output logic                     busy,
  output logic                     finished
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P     = PW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONVERT  = 3'd1,
    SKIP     = 3'd2,
    EMIT_DIG = 3'd3,
    EMIT_OVF = 3'd4,
    EMIT_CR  = 3'd5,
    EMIT_LF  = 3'd6,
    FIN      = 3'd7
  } state_t;

  localparam state_t TERM_ST = (EMIT_NEWLINE != 0) ? EMIT_CR : FIN;

  state_t                state_r, state_s;
  logic [BW-1:0]         bcd_r, bcd_s;
  logic [WIDTH-1:0]      shift_r, shift_s;
  logic [WIDTH-1:0]      cnt_r, cnt_s;
  logic [PW-1:0]         ptr_r, ptr_s;
  logic [1:0]            ovf_idx_r, ovf_idx_s;
  logic [7:0]            tx_data_r, tx_data_s;
  logic                  tx_valid_r, tx_valid_s;
  logic                  busy_r, busy_s;
  logic                  fin_r, fin_s;
  logic [BW+WIDTH-1:0]   cat_s;
  logic                  hs_s;

  // Add-3 to every nibble >= 5; 4-bit wrap is safe since such a nibble stays <= 12.
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Index of the most-significant nonzero digit, 0 when every digit is zero.
  function automatic logic [PW-1:0] msd(input logic [BW-1:0] b);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) p = PW'(i);
    end
    return p;
  endfunction

  function automatic logic [3:0] pick(input logic [BW-1:0] b, input logic [PW-1:0] p);
    logic [3:0] d;
    d = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (p == PW'(i)) d = b[4*i +: 4];
    end
    return d;
  endfunction

  assign hs_s        = tx_valid_r & tx.tx_ready;
  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign busy        = busy_r;
  assign finished    = fin_r;

  // Next-state and datapath update for the conversion/emit sequence.
  always_comb begin
    state_s   = state_r;
    bcd_s     = bcd_r;
    shift_s   = shift_r;
    cnt_s     = cnt_r;
    ptr_s     = ptr_r;
    ovf_idx_s = ovf_idx_r;
    cat_s     = {dabble(bcd_r), shift_r};
    case (state_r)
      IDLE: begin
        if (start) begin
          shift_s   = value;
          bcd_s     = {BW{1'b0}};
          cnt_s     = {WIDTH{1'b0}};
          ptr_s     = {PW{1'b0}};
          ovf_idx_s = 2'd0;
          state_s   = overflow ? EMIT_OVF : CONVERT;
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        bcd_s   = cat_s[BW+WIDTH-2:WIDTH-1];
        shift_s = {cat_s[WIDTH-2:0], 1'b0};
        cnt_s   = cnt_r + ONE_W;
        if (cnt_r == LAST_ITER) state_s = SKIP;
        else                    state_s = CONVERT;
      end
      SKIP: begin
        ptr_s   = msd(bcd_r);
        state_s = EMIT_DIG;
      end
      EMIT_DIG: begin
        if (hs_s) begin
          if (ptr_r == {PW{1'b0}}) state_s = TERM_ST;
          else                     ptr_s   = ptr_r - ONE_P;
        end else begin
          state_s = EMIT_DIG;
        end
      end
      EMIT_OVF: begin
        if (hs_s) begin
          if (ovf_idx_r == 2'd2) state_s   = TERM_ST;
          else                   ovf_idx_s = ovf_idx_r + 2'd1;
        end else begin
          state_s = EMIT_OVF;
        end
      end
      EMIT_CR: begin
        if (hs_s) state_s = EMIT_LF;
        else      state_s = EMIT_CR;
      end
      EMIT_LF: begin
        if (hs_s) state_s = FIN;
        else      state_s = EMIT_LF;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values decoded from the upcoming state so the outputs can be registered.
  always_comb begin
    tx_valid_s = 1'b0;
    tx_data_s  = 8'h00;
    busy_s     = (state_s != IDLE) && (state_s != FIN);
    fin_s      = (state_s == FIN);
    case (state_s)
      EMIT_DIG: begin
        tx_valid_s = 1'b1;
        tx_data_s  = 8'h30 + {4'h0, pick(bcd_s, ptr_s)};
      end
      EMIT_OVF: begin
        tx_valid_s = 1'b1;
        case (ovf_idx_s)
          2'd0:    tx_data_s = 8'h4F;
          2'd1:    tx_data_s = 8'h56;
          default: tx_data_s = 8'h46;
        endcase
      end
      EMIT_CR: begin
        tx_valid_s = 1'b1;
        tx_data_s  = 8'h0D;
      end
      EMIT_LF: begin
        tx_valid_s = 1'b1;
        tx_data_s  = 8'h0A;
      end
      default: begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bcd_r      <= {BW{1'b0}};
      shift_r    <= {WIDTH{1'b0}};
      cnt_r      <= {WIDTH{1'b0}};
      ptr_r      <= {PW{1'b0}};
      ovf_idx_r  <= 2'd0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      fin_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      bcd_r      <= bcd_s;
      shift_r    <= shift_s;
      cnt_r      <= cnt_s;
      ptr_r      <= ptr_s;
      ovf_idx_r  <= ovf_idx_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= busy_s;
      fin_r      <= fin_s;
    end
  end

endmodule
